// File: rtl/bin_to_bcd_seq.sv
// rtl/bin_to_bcd_seq.sv - sequential shift-and-add-3 binary to packed BCD converter
// Optional saturation on out-of-range input: define BIN_TO_BCD_OVERFLOW_EN.
module bin_to_bcd_seq #(
    parameter int NUM_DIGITS = 8,
    parameter int BIN_WIDTH  = 27
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [BIN_WIDTH-1:0]       bin,
    output logic                       busy,
    output logic                       done,
    output logic [NUM_DIGITS-1:0][3:0] bcd,
    output logic                       overflow
);

    localparam int SW = NUM_DIGITS * 4;
    localparam int CW = $clog2(BIN_WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [BIN_WIDTH-1:0] shreg_q, shreg_d;
    logic [SW-1:0]        scratch_q, scratch_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [SW-1:0]        bcd_q, bcd_d;
    logic                 done_q, done_d;
    logic [3:0]           nib;
    logic                 carry;
`ifdef BIN_TO_BCD_OVERFLOW_EN
    logic                 ovf_q, ovf_d;
    logic                 overflow_q, overflow_d;
`endif

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        bcd_d     = bcd_q;
        done_d    = 1'b0;
        nib       = 4'd0;
        carry     = 1'b0;
`ifdef BIN_TO_BCD_OVERFLOW_EN
        ovf_d      = ovf_q;
        overflow_d = overflow_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    shreg_d   = bin;
                    scratch_d = '0;
                    cnt_d     = CW'(BIN_WIDTH);
`ifdef BIN_TO_BCD_OVERFLOW_EN
                    ovf_d     = 1'b0;
`endif
                    state_d   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // Adjust each digit, then shift; the carry chain threads each digit's MSB upward.
                carry = shreg_q[BIN_WIDTH-1];
                for (int d = 0; d < NUM_DIGITS; d++) begin
                    nib = scratch_q[4*d +: 4] + ((scratch_q[4*d +: 4] >= 4'd5) ? 4'd3 : 4'd0);
                    scratch_d[4*d +: 4] = {nib[2:0], carry};
                    carry = nib[3];
                end
`ifdef BIN_TO_BCD_OVERFLOW_EN
                ovf_d = ovf_q | carry;
`endif
                shreg_d = {shreg_q[BIN_WIDTH-2:0], 1'b0};
                cnt_d   = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                bcd_d = scratch_q;
`ifdef BIN_TO_BCD_OVERFLOW_EN
                if (ovf_q) begin
                    bcd_d = {NUM_DIGITS{4'h9}};
                end
                overflow_d = ovf_q;
`endif
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            shreg_q    <= '0;
            scratch_q  <= '0;
            cnt_q      <= '0;
            bcd_q      <= '0;
            done_q     <= 1'b0;
`ifdef BIN_TO_BCD_OVERFLOW_EN
            ovf_q      <= 1'b0;
            overflow_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            scratch_q  <= scratch_d;
            cnt_q      <= cnt_d;
            bcd_q      <= bcd_d;
            done_q     <= done_d;
`ifdef BIN_TO_BCD_OVERFLOW_EN
            ovf_q      <= ovf_d;
            overflow_q <= overflow_d;
`endif
        end
    end

    assign busy = (state_q != ST_IDLE);
    assign done = done_q;
    assign bcd  = bcd_q;
`ifdef BIN_TO_BCD_OVERFLOW_EN
    assign overflow = overflow_q;
`else
    assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb/tb_bin_to_bcd_seq.sv - self-checking bench for bin_to_bcd_seq
module tb_bin_to_bcd_seq;

    localparam int ND = 8;
    localparam int BW = 27;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                start = 1'b0;
    logic [BW-1:0]       bin = '0;
    logic                busy;
    logic                done;
    logic [ND-1:0][3:0]  bcd;
    logic                overflow;

    always #5 clk = ~clk;

    bin_to_bcd_seq #(.NUM_DIGITS(ND), .BIN_WIDTH(BW)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .bin      (bin),
        .busy     (busy),
        .done     (done),
        .bcd      (bcd),
        .overflow (overflow)
    );

    typedef struct {
        logic [31:0] bcd;
        logic        ovf;
        int          cyc;
    } exp_t;

    typedef struct {
        logic [BW-1:0] bin;
        logic [31:0]   bcd;
        logic          ovf;
    } vec_t;

    exp_t  sb[$];
    exp_t  e;
    int    n_checks = 0;
    int    n_fail   = 0;
    int    cyc      = 0;
    logic [32:0] prev_out = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard consumer; between done pulses the outputs must not move.
    always @(posedge clk) begin
        #1;
        if (!reset) begin
            if (done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    check("bcd", 64'(bcd), 64'(e.bcd));
                    check("overflow", 64'(overflow), 64'(e.ovf));
                    check("latency", 64'(cyc), 64'(e.cyc));
                end
            end else begin
                check("bcd_stable", 64'({overflow, bcd}), 64'(prev_out));
            end
        end
        prev_out = {overflow, bcd};
    end

    task automatic start_conv(input logic [BW-1:0] v, input logic [31:0] eb, input logic eo);
        exp_t x;
        bin   = v;
        start = 1'b1;
        x.bcd = eb;
        x.ovf = eo;
        x.cyc = cyc + BW + 2;
        sb.push_back(x);
        @(negedge clk);
        start = 1'b0;
        bin   = BW'($urandom);
    endtask

    task automatic wait_empty();
        for (int i = 0; i < 200; i++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        check("done_timeout", 64'(sb.size()), 64'd0);
        sb.delete();
    endtask

    vec_t vecs[10];

    initial begin
        vecs[0] = '{27'd12_345_678, 32'h12345678, 1'b0};
        vecs[1] = '{27'd0,          32'h00000000, 1'b0};
        vecs[2] = '{27'd99_999_999, 32'h99999999, 1'b0};
`ifdef BIN_TO_BCD_OVERFLOW_EN
        vecs[3] = '{27'd100_000_000, 32'h99999999, 1'b1};
        vecs[4] = '{27'd134_217_727, 32'h99999999, 1'b1};
`else
        vecs[3] = '{27'd100_000_000, 32'h00000000, 1'b0};
        vecs[4] = '{27'd134_217_727, 32'h34217727, 1'b0};
`endif
        vecs[5] = '{27'd5,          32'h00000005, 1'b0};
        vecs[6] = '{27'd10,         32'h00000010, 1'b0};
        vecs[7] = '{27'd9_999,      32'h00009999, 1'b0};
        vecs[8] = '{27'd80_000_005, 32'h80000005, 1'b0};
        vecs[9] = '{27'd1,          32'h00000001, 1'b0};

        // Reset with start held high: nothing may start.
        reset = 1'b1;
        start = 1'b1;
        bin   = 27'd5;
        repeat (2) @(negedge clk);
        check("rst_bcd", 64'(bcd), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        reset = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_no_conv", 64'(busy), 64'd0);

        // Table of single conversions.
        for (int i = 0; i < 10; i++) begin
            start_conv(vecs[i].bin, vecs[i].bcd, vecs[i].ovf);
            wait_empty();
        end

        // Back-to-back: second start issued while done is high.
        start_conv(27'd0, 32'h00000000, 1'b0);
        for (int i = 0; i < 100; i++) begin
            if (done) break;
            @(negedge clk);
        end
        check("b2b_done_seen", 64'(done), 64'd1);
        start_conv(27'd99_999_999, 32'h99999999, 1'b0);
        wait_empty();

        // Start while busy is dropped.
        start_conv(27'd42, 32'h00000042, 1'b0);
        repeat (4) @(negedge clk);
        check("busy_mid", 64'(busy), 64'd1);
        bin   = 27'd7;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_empty();
        repeat (40) @(negedge clk);
        check("ignored_idle", 64'(busy), 64'd0);

        // Reset mid-conversion aborts without done.
        start_conv(27'd555, 32'h00000555, 1'b0);
        repeat (10) @(negedge clk);
        reset = 1'b1;
        sb.delete();
        @(negedge clk);
        reset = 1'b0;
        check("abort_bcd", 64'(bcd), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        repeat (40) @(negedge clk);
        start_conv(27'd9, 32'h00000009, 1'b0);
        wait_empty();

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
